// File: rtl/multi_tick_divider_pkg.sv
// Shared types and helpers for the multi-channel tick divider.
// Channel modes match the encoding of the cfg_mode port.
package multi_tick_divider_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_RSVD     = 2'b11
    } tick_mode_t;

    // Wide enough for any practical counter; callers cast in and out.
    localparam int CLAMP_W = 64;

    // A divisor of zero behaves as one, so the reload value div-1 can never underflow.
    function automatic logic [CLAMP_W-1:0] clamp_divisor(input logic [CLAMP_W-1:0] divisor);
        return (divisor == '0) ? CLAMP_W'(1) : divisor;
    endfunction

    function automatic logic mode_is_legal(input logic [1:0] mode);
        return mode != MODE_RSVD;
    endfunction

endpackage

// File: rtl/multi_tick_divider_channel.sv
// One divider channel: down-counter with reload at zero, registered tick/toggle/busy.
//
// state          | meaning
// MODE_OFF       | idle, count frozen, no ticks
// MODE_PERIODIC  | counting down, tick and reload every time count hits 0
// MODE_ONESHOT   | counting down, single tick then fall back to MODE_OFF
module tick_divider_channel
    import multi_tick_divider_pkg::*;
#(
    parameter int                       COUNTER_WIDTH   = 25,
    parameter logic [COUNTER_WIDTH-1:0] DEFAULT_DIVISOR = 25'h1000000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     load,
    input  tick_mode_t               load_mode,
    input  logic [COUNTER_WIDTH-1:0] load_divisor,
    output logic                     tick,
    output logic                     toggle,
    output logic                     busy
);

    localparam logic [COUNTER_WIDTH-1:0] RESET_DIV =
        (DEFAULT_DIVISOR == '0) ? COUNTER_WIDTH'(1) : DEFAULT_DIVISOR;

    tick_mode_t               mode_q, mode_d;
    logic [COUNTER_WIDTH-1:0] div_q, div_d;
    logic [COUNTER_WIDTH-1:0] count_q, count_d;
    logic                     tick_q, tick_d;
    logic                     toggle_q, toggle_d;
    logic                     busy_q, busy_d;

    always_comb begin
        mode_d   = mode_q;
        div_d    = div_q;
        count_d  = count_q;
        tick_d   = 1'b0;
        toggle_d = toggle_q;
        busy_d   = busy_q;

        if (load) begin
            // A load always restarts the period and swallows any tick due this edge.
            mode_d  = load_mode;
            div_d   = load_divisor;
            count_d = load_divisor - COUNTER_WIDTH'(1);
            busy_d  = (load_mode != MODE_OFF);
        end else if (mode_q == MODE_OFF) begin
            busy_d = 1'b0;
        end else if (count_q != '0) begin
            count_d = count_q - COUNTER_WIDTH'(1);
        end else begin
            tick_d   = 1'b1;
            toggle_d = ~toggle_q;
            count_d  = div_q - COUNTER_WIDTH'(1);
            if (mode_q == MODE_ONESHOT) begin
                mode_d = MODE_OFF;
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q   <= MODE_PERIODIC;
            div_q    <= RESET_DIV;
            count_q  <= RESET_DIV - COUNTER_WIDTH'(1);
            tick_q   <= 1'b0;
            toggle_q <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            mode_q   <= mode_d;
            div_q    <= div_d;
            count_q  <= count_d;
            tick_q   <= tick_d;
            toggle_q <= toggle_d;
            busy_q   <= busy_d;
        end
    end

    assign tick   = tick_q;
    assign toggle = toggle_q;
    assign busy   = busy_q;

endmodule

// File: rtl/multi_tick_divider.sv
// Multi-channel programmable tick/toggle generator with a valid/ready config port.
// Decodes config requests, flags illegal ones, and fans loads out to the channels.
module multi_tick_divider
    import multi_tick_divider_pkg::*;
#(
    parameter int                       NUM_CHANNELS    = 4,
    parameter int                       COUNTER_WIDTH   = 25,
    parameter logic [COUNTER_WIDTH-1:0] DEFAULT_DIVISOR = 25'h1000000,
    localparam int                      CH_IDX_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [CH_IDX_W-1:0]      cfg_channel,
    input  logic [COUNTER_WIDTH-1:0] cfg_divisor,
    input  logic [1:0]               cfg_mode,
    output logic                     cfg_error,
    output logic [NUM_CHANNELS-1:0]  tick,
    output logic [NUM_CHANNELS-1:0]  toggle,
    output logic [NUM_CHANNELS-1:0]  busy
);

    logic                     cfg_ready_q, cfg_ready_d;
    logic                     cfg_error_q, cfg_error_d;
    logic                     accept;
    logic                     chan_ok;
    logic                     mode_ok;
    logic                     load_ok;
    logic [COUNTER_WIDTH-1:0] div_eff;
    logic [NUM_CHANNELS-1:0]  load_vec;

    assign accept  = cfg_valid && cfg_ready_q;
    assign chan_ok = (32'(cfg_channel) < NUM_CHANNELS);
    assign mode_ok = mode_is_legal(cfg_mode);
    assign load_ok = accept && chan_ok && mode_ok;
    assign div_eff = COUNTER_WIDTH'(clamp_divisor(CLAMP_W'(cfg_divisor)));

    always_comb begin
        cfg_ready_d = 1'b1;
        cfg_error_d = accept && !(chan_ok && mode_ok);
    end

    // Ready stays low for the reset cycle so nothing is accepted while channels reload.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cfg_ready_q <= 1'b0;
            cfg_error_q <= 1'b0;
        end else begin
            cfg_ready_q <= cfg_ready_d;
            cfg_error_q <= cfg_error_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign cfg_error = cfg_error_q;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        assign load_vec[i] = load_ok && (32'(cfg_channel) == i);

        tick_divider_channel #(
            .COUNTER_WIDTH   (COUNTER_WIDTH),
            .DEFAULT_DIVISOR (DEFAULT_DIVISOR)
        ) u_channel (
            .clk          (clk),
            .reset_n      (reset_n),
            .load         (load_vec[i]),
            .load_mode    (tick_mode_t'(cfg_mode)),
            .load_divisor (div_eff),
            .tick         (tick[i]),
            .toggle       (toggle[i]),
            .busy         (busy[i])
        );
    end

endmodule

// File: tb/tb_multi_tick_divider.sv
// Directed bench for multi_tick_divider: three channels, so channel index 3 is out of range.
// Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
module tb_multi_tick_divider;

    localparam int NCH = 3;
    localparam int CW  = 25;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [1:0]      cfg_channel = 2'd0;
    logic [CW-1:0]   cfg_divisor = '0;
    logic [1:0]      cfg_mode = 2'd0;
    logic            cfg_error;
    logic [NCH-1:0]  tick;
    logic [NCH-1:0]  toggle;
    logic [NCH-1:0]  busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multi_tick_divider #(
        .NUM_CHANNELS    (NCH),
        .COUNTER_WIDTH   (CW),
        .DEFAULT_DIVISOR (25'd8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_channel (cfg_channel),
        .cfg_divisor (cfg_divisor),
        .cfg_mode    (cfg_mode),
        .cfg_error   (cfg_error),
        .tick        (tick),
        .toggle      (toggle),
        .busy        (busy)
    );

    typedef struct {
        logic          valid;
        logic [1:0]    ch;
        logic [CW-1:0] div;
        logic [1:0]    mode;
        logic [2:0]    e_tick;
        logic [2:0]    e_tog;
        logic          e_err;
    } vec_t;

    vec_t vec [1:30];

    function automatic vec_t mk(input int v, input int ch, input int div, input int mode,
                                input int t, input int g, input int e);
        vec_t r;
        r.valid  = (v != 0);
        r.ch     = 2'(ch);
        r.div    = CW'(div);
        r.mode   = 2'(mode);
        r.e_tick = 3'(t);
        r.e_tog  = 3'(g);
        r.e_err  = (e != 0);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_cfg(input int ch, input int div, input int mode);
        cfg_valid   = 1'b1;
        cfg_channel = 2'(ch);
        cfg_divisor = CW'(div);
        cfg_mode    = 2'(mode);
    endtask

    // Two reset edges, then release; afterwards the next edge is R+1.
    task automatic do_reset();
        cfg_valid = 1'b0;
        reset_n   = 1'b0;
        step();
        step();
        check("reset_state", 32'({tick, toggle, busy, cfg_ready, cfg_error}),
              32'({3'b000, 3'b000, 3'b111, 1'b1 ^ 1'b1, 1'b0}));
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] et, eg;

        // Reference table: cycle-by-cycle after a reset, divisor 8 on every channel.
        vec[1]  = mk(0, 0,  0, 0, 'b000, 'b000, 0);
        vec[2]  = mk(1, 1, 10, 1, 'b000, 'b000, 0);
        vec[3]  = mk(0, 0,  0, 0, 'b000, 'b000, 0);
        vec[4]  = mk(0, 0,  0, 0, 'b000, 'b000, 0);
        vec[5]  = mk(1, 3,  2, 1, 'b000, 'b000, 1);
        vec[6]  = mk(0, 0,  0, 0, 'b000, 'b000, 0);
        vec[7]  = mk(0, 0,  0, 0, 'b000, 'b000, 0);
        vec[8]  = mk(1, 0,  8, 1, 'b100, 'b100, 0);
        vec[9]  = mk(0, 0,  0, 0, 'b000, 'b100, 0);
        vec[10] = mk(0, 0,  0, 0, 'b000, 'b100, 0);
        vec[11] = mk(0, 0,  0, 0, 'b000, 'b100, 0);
        vec[12] = mk(0, 0,  0, 0, 'b010, 'b110, 0);
        vec[13] = mk(0, 0,  0, 0, 'b000, 'b110, 0);
        vec[14] = mk(1, 1,  2, 3, 'b000, 'b110, 1);
        vec[15] = mk(0, 0,  0, 0, 'b000, 'b110, 0);
        vec[16] = mk(0, 0,  0, 0, 'b101, 'b011, 0);
        vec[17] = mk(0, 0,  0, 0, 'b000, 'b011, 0);
        vec[18] = mk(0, 0,  0, 0, 'b000, 'b011, 0);
        vec[19] = mk(0, 0,  0, 0, 'b000, 'b011, 0);
        vec[20] = mk(1, 1,  4, 1, 'b000, 'b011, 0);
        vec[21] = mk(0, 0,  0, 0, 'b000, 'b011, 0);
        vec[22] = mk(0, 0,  0, 0, 'b000, 'b011, 0);
        vec[23] = mk(0, 0,  0, 0, 'b000, 'b011, 0);
        vec[24] = mk(0, 0,  0, 0, 'b111, 'b100, 0);
        vec[25] = mk(0, 0,  0, 0, 'b000, 'b100, 0);
        vec[26] = mk(0, 0,  0, 0, 'b000, 'b100, 0);
        vec[27] = mk(0, 0,  0, 0, 'b000, 'b100, 0);
        vec[28] = mk(0, 0,  0, 0, 'b010, 'b110, 0);
        vec[29] = mk(0, 0,  0, 0, 'b000, 'b110, 0);
        vec[30] = mk(0, 0,  0, 0, 'b000, 'b110, 0);

        // Reset release: all channels tick every 8; ch1 moved to period 5 at R+10.
        do_reset();
        for (int k = 1; k <= 32; k++) begin
            if (k == 10) drive_cfg(1, 5, 1);
            step();
            cfg_valid = 1'b0;
            et[0] = (k % 8 == 0);
            eg[0] = ((k / 8) % 2 == 1);
            et[2] = et[0];
            eg[2] = eg[0];
            if (k <= 10) begin
                et[1] = et[0];
                eg[1] = eg[0];
            end else begin
                et[1] = ((k - 10) % 5 == 0);
                eg[1] = (((k - 10) / 5) % 2 == 0);
            end
            check($sformatf("release k=%0d", k),
                  32'({tick, toggle, busy, cfg_ready, cfg_error}),
                  32'({et, eg, 3'b111, 1'b1, 1'b0}));
        end

        // One-shot ch2 D=3 accepted at R+2: tick at R+5, busy falls with it, then silence.
        begin
            int extra;
            do_reset();
            step();
            drive_cfg(2, 3, 2);
            step();
            cfg_valid = 1'b0;
            check("oneshot_armed", 32'({tick[2], busy[2]}), 32'(2'b01));
            step();
            step();
            check("oneshot_wait", 32'({tick[2], busy[2]}), 32'(2'b01));
            step();
            check("oneshot_fire", 32'({tick[2], toggle[2], busy[2]}), 32'(3'b110));
            extra = 0;
            for (int k = 0; k < 50; k++) begin
                step();
                if (tick[2] || busy[2]) extra++;
            end
            check("oneshot_quiet", 32'(extra), 32'(0));
        end

        // D=0 clamps to 1 on ch0; then reload with D=1 suppresses one tick.
        do_reset();
        step();
        drive_cfg(0, 0, 1);
        step();
        cfg_valid = 1'b0;
        check("d0_accept", 32'({tick[0], toggle[0]}), 32'(2'b00));
        for (int k = 3; k <= 8; k++) begin
            step();
            check($sformatf("d0 k=%0d", k), 32'({tick[0], toggle[0]}),
                  32'({1'b1, 1'((k - 2) % 2)}));
        end
        drive_cfg(0, 1, 1);
        step();
        cfg_valid = 1'b0;
        check("d1_accept", 32'({tick[0], toggle[0]}), 32'(2'b00));
        for (int k = 10; k <= 14; k++) begin
            step();
            check($sformatf("d1 k=%0d", k), 32'({tick[0], toggle[0]}),
                  32'({1'b1, 1'((k - 9) % 2)}));
        end

        // Table: reconfig mid-count, suppressed tick, bad channel, reserved mode.
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            cfg_valid   = vec[k].valid;
            cfg_channel = vec[k].ch;
            cfg_divisor = vec[k].div;
            cfg_mode    = vec[k].mode;
            step();
            cfg_valid = 1'b0;
            check($sformatf("table k=%0d", k),
                  32'({tick, toggle, busy, cfg_ready, cfg_error}),
                  32'({vec[k].e_tick, vec[k].e_tog, 3'b111, 1'b1, vec[k].e_err}));
        end

        // Reset coincident with an otherwise acceptable request: reset wins.
        reset_n = 1'b0;
        drive_cfg(0, 2, 1);
        step();
        cfg_valid = 1'b0;
        check("reset_vs_cfg", 32'({tick, toggle, busy, cfg_ready, cfg_error}),
              32'({3'b000, 3'b000, 3'b111, 1'b0, 1'b0}));
        reset_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("post_reset k=%0d", k), 32'({tick, toggle}),
                  (k == 8) ? 32'({3'b111, 3'b111}) : 32'(0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
